// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: LSB-first serial-to-parallel word receiver.
// A frame opens on a bit_valid bit that carries start and closes after Nbits
// accepted bits. Each completed word goes to a one-entry output register with
// a valid/ready handshake. Dropped words set a sticky overrun flag.
module sipo_frame_receiver #(
  parameter int Nbits = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     serial_in,
  input  logic                     bit_valid,
  input  logic                     start,
  input  logic                     data_ready,
  output logic [Nbits-1:0]         data_out,
  output logic                     data_valid,
  output logic                     overrun,
  output logic                     busy,
  output logic [$clog2(Nbits)-1:0] bit_count
);

  localparam int CW = $clog2(Nbits);
  localparam logic [CW-1:0] LAST_BIT = CW'(Nbits - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [Nbits-1:0] shift_reg;
  logic [Nbits-1:0] shift_next;
  logic             take_bit;
  logic             word_done;

  // New bits enter at the MSB, so the first bit of a frame reaches bit 0 after Nbits shifts.
  assign shift_next = {serial_in, shift_reg[Nbits-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the values from before the edge, whatever the block order is.
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A start bit opens or re-syncs a frame. The last bit closes the frame.
  always_comb begin
    // NOTE: the default assignment comes first. Paths that do not assign the
    // signal then keep this value, and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bit_valid && start) state_d = RECV;
      RECV: if (bit_valid && !start && bit_count == LAST_BIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and control decode from the current state.
  always_comb begin
    busy      = (state_q == RECV);
    take_bit  = bit_valid && (start || state_q == RECV);
    word_done = (state_q == RECV) && bit_valid && !start && (bit_count == LAST_BIT);
  end

  // Datapath: the shift register and the bit counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (take_bit) begin
      shift_reg <= shift_next;
      if (start)          bit_count <= CW'(1);
      else if (word_done) bit_count <= '0;
      else                bit_count <= bit_count + CW'(1);
    end
  end

  // Output stage. A word completes into an empty or draining slot, otherwise it is
  // dropped and overrun is set. Without a completion, a consumer handshake empties the slot.
  always_ff @(posedge clk) begin
    if (clr) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      if (!data_valid || data_ready) begin
        data_out   <= shift_next;
        data_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb_sipo_frame_receiver: directed and randomized checks of sipo_frame_receiver.
// A behavioural frame model gives the expected value of every output after every edge.
module tb_sipo_frame_receiver;

  localparam int N = 8;

  logic                   clk = 1'b0;
  logic                   clr = 1'b1;
  logic                   serial_in = 1'b0;
  logic                   bit_valid = 1'b0;
  logic                   start = 1'b0;
  logic                   data_ready = 1'b0;
  logic [N-1:0]           data_out;
  logic                   data_valid;
  logic                   overrun;
  logic                   busy;
  logic [$clog2(N)-1:0]   bit_count;

  int checks = 0;
  int failures = 0;

  // Reference model: the frame is a list of received bits.
  // Word value is the sum of bit * 2^position.
  bit m_in_frame;
  int m_idx;
  int m_word;
  int m_out;
  bit m_valid;
  bit m_ovr;

  sipo_frame_receiver #(.Nbits(N)) dut (
    .clk        (clk),
    .clr        (clr),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .start      (start),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .busy       (busy),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge, using the inputs as they are presented.
  function automatic void model_step();
    bit done;
    done = 1'b0;
    if (clr) begin
      m_in_frame = 1'b0;
      m_idx      = 0;
      m_word     = 0;
      m_out      = 0;
      m_valid    = 1'b0;
      m_ovr      = 1'b0;
      return;
    end
    if (bit_valid) begin
      if (start) begin
        m_in_frame = 1'b1;
        m_word     = int'(serial_in);
        m_idx      = 1;
      end else if (m_in_frame) begin
        m_word = m_word + (int'(serial_in) << m_idx);
        m_idx  = m_idx + 1;
        if (m_idx == N) begin
          done       = 1'b1;
          m_in_frame = 1'b0;
          m_idx      = 0;
        end
      end
    end
    if (done) begin
      if (!m_valid || data_ready) begin
        m_out   = m_word;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && data_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("data_out",   32'(data_out),   32'(m_out));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("busy",       32'(busy),       32'(m_in_frame));
    check("bit_count",  32'(bit_count),  32'(m_idx));
  endtask

  // Present one cycle of inputs, clock it, and compare all outputs 1 time unit after the edge.
  task automatic cycle(input logic bv, input logic b, input logic st, input logic rdy);
    bit_valid  = bv;
    serial_in  = b;
    start      = st;
    data_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
  endtask

  // Send one word LSB first. Before each bit, insert 0..gapmax idle cycles.
  task automatic send_word(input logic [N-1:0] w, input int gapmax,
                           input logic rdy, input logic last_rdy);
    for (int i = 0; i < N; i++) begin
      int gaps;
      gaps = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (gaps) cycle(1'b0, 1'($urandom), 1'b0, rdy);
      cycle(1'b1, w[i], (i == 0), (i == N - 1) ? last_rdy : rdy);
    end
  endtask

  initial begin
    // Reset state.
    do_clr();
    do_clr();
    check("rst_out_zero", 32'(data_out), 32'h0);

    // Basic frame.
    send_word(8'hA5, 0, 1'b0, 1'b0);
    check("basic_a5", 32'(data_out), 32'hA5);
    check("basic_valid", 32'(data_valid), 32'h1);

    // Gaps, then stray bits in IDLE.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h3C, 3, 1'b0, 1'b0);
    check("gaps_3c", 32'(data_out), 32'h3C);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    check("stray_out", 32'(data_out), 32'h3C);
    check("stray_cnt", 32'(bit_count), 32'h0);

    // Back-to-back with ready.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h12, 0, 1'b1, 1'b1);
    check("b2b_12", 32'(data_out), 32'h12);
    send_word(8'h34, 0, 1'b1, 1'b1);
    check("b2b_34", 32'(data_out), 32'h34);
    check("b2b_ovr", 32'(overrun), 32'h0);

    // Simultaneous accept and complete.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h6B, 0, 1'b0, 1'b0);
    send_word(8'hC7, 0, 1'b0, 1'b1);
    check("simul_c7", 32'(data_out), 32'hC7);
    check("simul_valid", 32'(data_valid), 32'h1);
    check("simul_ovr", 32'(overrun), 32'h0);

    // Re-sync after 4 bits.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    send_word(8'hF0, 0, 1'b0, 1'b0);
    check("resync_f0", 32'(data_out), 32'hF0);

    // Overrun.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h55, 0, 1'b0, 1'b0);
    send_word(8'hAA, 1, 1'b0, 1'b0);
    check("ovr_out", 32'(data_out), 32'h55);
    check("ovr_valid", 32'(data_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_drain", 32'(data_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Reset mid-frame, then a full frame.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, (i == 0), 1'b0);
    do_clr();
    check("clr_out", 32'(data_out), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_ovr", 32'(overrun), 32'h0);
    check("clr_cnt", 32'(bit_count), 32'h0);
    send_word(8'h81, 2, 1'b0, 1'b0);
    check("post_clr_81", 32'(data_out), 32'h81);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom_range(199, 0) == 0);
      cycle(($urandom_range(3, 0) != 0), 1'($urandom),
            ($urandom_range(9, 0) == 0), ($urandom_range(2, 0) == 0));
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
